// File: rtl/alu_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : alu_arbiter_if
// Purpose : Bundles the two requester channels, the response channel, the
//           shared-ALU channel and the BUSY flag of alu_arbiter.
// Ports   : none (signal bundle only)
//   req0_*/req1_* : valid, op1, op2, oprn in; ready out of the arbiter
//   rsp_*         : valid, id, out, zero, err out; rsp_ready in
//   alu_*         : op1, op2, oprn out; alu_out, alu_zero in
//   busy          : arbiter not in IDLE
// Modports: slave  = the arbiter side
//           master = the environment (requesters, consumer, ALU)
// Revision: 1.0  initial release
// ============================================================================
interface alu_arbiter_if;
  logic        req0_valid;
  logic [31:0] req0_op1;
  logic [31:0] req0_op2;
  logic [5:0]  req0_oprn;
  logic        req0_ready;

  logic        req1_valid;
  logic [31:0] req1_op1;
  logic [31:0] req1_op2;
  logic [5:0]  req1_oprn;
  logic        req1_ready;

  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_out;
  logic        rsp_zero;
  logic        rsp_err;
  logic        rsp_ready;

  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [5:0]  alu_oprn;
  logic [31:0] alu_out;
  logic        alu_zero;

  logic        busy;

  modport slave (
    input  req0_valid, req0_op1, req0_op2, req0_oprn,
    input  req1_valid, req1_op1, req1_op2, req1_oprn,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_out, rsp_zero, rsp_err,
    input  rsp_ready,
    output alu_op1, alu_op2, alu_oprn,
    input  alu_out, alu_zero,
    output busy
  );

  modport master (
    output req0_valid, req0_op1, req0_op2, req0_oprn,
    output req1_valid, req1_op1, req1_op2, req1_oprn,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_out, rsp_zero, rsp_err,
    output rsp_ready,
    input  alu_op1, alu_op2, alu_oprn,
    output alu_out, alu_zero,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : alu_arbiter
// Purpose : Round-robin arbiter sharing one external ALU between two
//           requesters. One operation in flight at a time; the result is
//           held on the response channel until consumed.
// Ports   :
//   clk   in  system clock, rising edge
//   rst_n in  asynchronous active-low reset
//   bus   alu_arbiter_if.slave (requests, response, ALU drive, busy)
// Params  : MUL_WAIT (0..15) extra cycles granted to opcode 0x03
// Revision: 1.0  initial release
// ============================================================================
module alu_arbiter #(
  parameter int MUL_WAIT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [5:0] OPRN_MUL   = 6'h03;
  localparam logic [5:0] OPRN_MAX   = 6'h09;
  localparam logic [3:0] WAIT_LOAD  = 4'(MUL_WAIT);
  localparam logic       HAS_WAIT   = (MUL_WAIT > 0);

  state_t      state_q,    state_d;
  logic        last_gnt_q, last_gnt_d;
  logic [3:0]  cnt_q,      cnt_d;
  logic [31:0] op1_q,      op1_d;
  logic [31:0] op2_q,      op2_d;
  logic [5:0]  oprn_q,     oprn_d;
  logic        id_q,       id_d;
  logic [31:0] out_q,      out_d;
  logic        zero_q,     zero_d;
  logic        err_q,      err_d;

  logic        win;
  logic        accept;
  logic        sel_legal;
  logic [31:0] sel_op1;
  logic [31:0] sel_op2;
  logic [5:0]  sel_oprn;

  // Arbitration: a lone requester wins; on a tie the one not granted
  // last time wins. last_gnt resets to 1 so requester 0 takes the first tie.
  always_comb begin
    win       = bus.req1_valid & (~bus.req0_valid | ~last_gnt_q);
    sel_op1   = win ? bus.req1_op1  : bus.req0_op1;
    sel_op2   = win ? bus.req1_op2  : bus.req0_op2;
    sel_oprn  = win ? bus.req1_oprn : bus.req0_oprn;
    sel_legal = (sel_oprn != 6'd0) && (sel_oprn <= OPRN_MAX);
  end

  // READY is gated by rst_n so it reads 0 while reset is held even though
  // the requester inputs may be active.
  always_comb begin
    bus.req0_ready = rst_n && (state_q == IDLE) && bus.req0_valid && !win;
    bus.req1_ready = rst_n && (state_q == IDLE) && bus.req1_valid &&  win;
  end

  assign accept = bus.req0_ready | bus.req1_ready;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    oprn_d     = oprn_q;
    id_d       = id_q;
    out_d      = out_q;
    zero_d     = zero_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op1_d      = sel_op1;
          op2_d      = sel_op2;
          oprn_d     = sel_oprn;
          id_d       = win;
          last_gnt_d = win;
          if (sel_legal) begin
            err_d   = 1'b0;
            state_d = EXEC;
          end else begin
            // Illegal opcode: answer directly without touching the ALU.
            out_d   = 32'd0;
            zero_d  = 1'b1;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end

      EXEC: begin
        if ((oprn_q == OPRN_MUL) && HAS_WAIT) begin
          cnt_d   = WAIT_LOAD;
          state_d = WAIT;
        end else begin
          out_d   = bus.alu_out;
          zero_d  = bus.alu_zero;
          err_d   = 1'b0;
          state_d = RESP;
        end
      end

      WAIT: begin
        // Counter holds the remaining wait cycles including this one.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          out_d   = bus.alu_out;
          zero_d  = bus.alu_zero;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      cnt_q      <= 4'd0;
      op1_q      <= 32'd0;
      op2_q      <= 32'd0;
      oprn_q     <= 6'd0;
      id_q       <= 1'b0;
      out_q      <= 32'd0;
      zero_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      oprn_q     <= oprn_d;
      id_q       <= id_d;
      out_q      <= out_d;
      zero_q     <= zero_d;
      err_q      <= err_d;
    end
  end

  assign bus.alu_op1   = op1_q;
  assign bus.alu_op2   = op2_q;
  assign bus.alu_oprn  = oprn_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_out   = out_q;
  assign bus.rsp_zero  = zero_q;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_alu_arbiter
// Purpose : Self-checking bench for alu_arbiter: vector table of requests
//           with a response scoreboard, plus stall and reset-abort sequences.
// Revision: 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

  localparam int MUL_WAIT = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_arbiter_if bus();

  alu_arbiter #(.MUL_WAIT(MUL_WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared ALU placed outside the arbiter.
  function automatic logic [31:0] alu_model(input logic [5:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      6'h01:   return a + b;
      6'h02:   return a - b;
      6'h03:   return a * b;
      6'h04:   return a & b;
      6'h05:   return a | b;
      6'h06:   return a ^ b;
      6'h07:   return a << b[4:0];
      6'h08:   return a >> b[4:0];
      6'h09:   return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  assign bus.alu_out  = alu_model(bus.alu_oprn, bus.alu_op1, bus.alu_op2);
  assign bus.alu_zero = (bus.alu_out == 32'd0);

  typedef struct {
    logic        v0;
    logic        v1;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [5:0]  o0;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [5:0]  o1;
    logic        id;
    logic [31:0] out;
    logic        zero;
    logic        err;
    int          lat;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] out;
    logic        zero;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drop_inputs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_op1   = $urandom;
    bus.req0_op2   = $urandom;
    bus.req0_oprn  = 6'h03;
    bus.req1_op1   = $urandom;
    bus.req1_op2   = $urandom;
    bus.req1_oprn  = 6'h01;
  endtask

  // Drive one vector, check the grant, queue the expected response and
  // check the latency from the READY cycle to the first RSP_VALID cycle.
  task automatic issue(input vec_t v);
    bit found;
    int k;
    rsp_t e;
    bus.req0_valid = v.v0;  bus.req0_op1 = v.a0; bus.req0_op2 = v.b0; bus.req0_oprn = v.o0;
    bus.req1_valid = v.v1;  bus.req1_op1 = v.a1; bus.req1_op2 = v.b1; bus.req1_oprn = v.o1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      chk("grant_timeout", 32'd0, 32'd1);
      drop_inputs();
      return;
    end
    chk("grant_id", {31'd0, bus.req1_ready}, {31'd0, v.id});
    chk("grant_onehot", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
    k = cyc;
    e.id = v.id; e.out = v.out; e.zero = v.zero; e.err = v.err;
    sb.push_back(e);
    @(posedge clk); #1;
    drop_inputs();
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        found = 1;
        break;
      end
    end
    if (!found) chk("rsp_timeout", 32'd0, 32'd1);
    else        chk("latency", 32'(cyc - k), 32'(v.lat));
    @(posedge clk); #1;
  endtask

  // Scoreboard consumer: a response is retired when it is consumed.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        chk("rsp_id",   {31'd0, bus.rsp_id},   {31'd0, e.id});
        chk("rsp_out",  bus.rsp_out,           e.out);
        chk("rsp_zero", {31'd0, bus.rsp_zero}, {31'd0, e.zero});
        chk("rsp_err",  {31'd0, bus.rsp_err},  {31'd0, e.err});
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready0"},   {31'd0, bus.req0_ready}, 32'd0);
    chk({tag, "_ready1"},   {31'd0, bus.req1_ready}, 32'd0);
    chk({tag, "_rsp_valid"},{31'd0, bus.rsp_valid},  32'd0);
    chk({tag, "_busy"},     {31'd0, bus.busy},       32'd0);
    chk({tag, "_rsp_out"},  bus.rsp_out,             32'd0);
    chk({tag, "_rsp_zero"}, {31'd0, bus.rsp_zero},   32'd0);
    chk({tag, "_rsp_err"},  {31'd0, bus.rsp_err},    32'd0);
    chk({tag, "_alu_op1"},  bus.alu_op1,             32'd0);
    chk({tag, "_alu_op2"},  bus.alu_op2,             32'd0);
    chk({tag, "_alu_oprn"}, {26'd0, bus.alu_oprn},   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //            v0 v1  a0            b0            o0     a1            b1            o1     id   out           z  e  lat
    tbl[0]  = '{1'b1, 1'b1, 32'd7,      32'd7,      6'h02, 32'hF0,     32'h0F,     6'h05, 1'b0, 32'd0,       1'b1, 1'b0, 2};
    tbl[1]  = '{1'b1, 1'b1, 32'd7,      32'd7,      6'h02, 32'hF0,     32'h0F,     6'h05, 1'b1, 32'hFF,      1'b0, 1'b0, 2};
    tbl[2]  = '{1'b1, 1'b1, 32'd7,      32'd7,      6'h02, 32'hF0,     32'h0F,     6'h05, 1'b0, 32'd0,       1'b1, 1'b0, 2};
    tbl[3]  = '{1'b1, 1'b1, 32'd7,      32'd7,      6'h02, 32'hF0,     32'h0F,     6'h05, 1'b1, 32'hFF,      1'b0, 1'b0, 2};
    tbl[4]  = '{1'b1, 1'b0, 32'd5,      32'd3,      6'h01, 32'd0,      32'd0,      6'h00, 1'b0, 32'd8,       1'b0, 1'b0, 2};
    tbl[5]  = '{1'b0, 1'b1, 32'd0,      32'd0,      6'h00, 32'd6,      32'd7,      6'h03, 1'b1, 32'd42,      1'b0, 1'b0, 3};
    tbl[6]  = '{1'b1, 1'b0, 32'd5,      32'd3,      6'h0C, 32'd0,      32'd0,      6'h00, 1'b0, 32'd0,       1'b1, 1'b1, 1};
    tbl[7]  = '{1'b0, 1'b1, 32'd0,      32'd0,      6'h00, 32'd4,      32'd4,      6'h00, 1'b1, 32'd0,       1'b1, 1'b1, 1};
    tbl[8]  = '{1'b1, 1'b0, 32'd9,      32'd1,      6'h3F, 32'd0,      32'd0,      6'h00, 1'b0, 32'd0,       1'b1, 1'b1, 1};
    tbl[9]  = '{1'b0, 1'b1, 32'd0,      32'd0,      6'h00, 32'd2,      32'd2,      6'h0A, 1'b1, 32'd0,       1'b1, 1'b1, 1};
    tbl[10] = '{1'b1, 1'b0, 32'hFFFF0000, 32'h0000FFFF, 6'h09, 32'd0,  32'd0,      6'h00, 1'b0, 32'd0,       1'b1, 1'b0, 2};
    tbl[11] = '{1'b1, 1'b0, 32'd1,      32'd4,      6'h07, 32'd0,      32'd0,      6'h00, 1'b0, 32'd16,      1'b0, 1'b0, 2};
    tbl[12] = '{1'b1, 1'b1, 32'hF0F0,   32'h0FF0,   6'h04, 32'hA5A5A5A5, 32'h0F0F0F0F, 6'h06, 1'b1, 32'hAAAAAAAA, 1'b0, 1'b0, 2};
    tbl[13] = '{1'b1, 1'b1, 32'h80000000, 32'd31,   6'h08, 32'd1,      32'd1,      6'h02, 1'b0, 32'd1,       1'b0, 1'b0, 2};
    tbl[14] = '{1'b0, 1'b1, 32'd0,      32'd0,      6'h00, 32'h10000,  32'h10000,  6'h03, 1'b1, 32'd0,       1'b1, 1'b0, 3};

    // Reset: outputs must read zero even with requests presented.
    bus.rsp_ready  = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_op1 = 32'd1; bus.req0_op2 = 32'd2; bus.req0_oprn = 6'h01;
    bus.req1_valid = 1'b1; bus.req1_op1 = 32'd3; bus.req1_op2 = 32'd4; bus.req1_oprn = 6'h01;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    drop_inputs();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven requests.
    for (int i = 0; i < 15; i++) issue(tbl[i]);

    // Response stall: fields stable, no grants, BUSY high.
    bus.rsp_ready = 1'b0;
    v = '{1'b1, 1'b0, 32'd9, 32'd1, 6'h01, 32'd0, 32'd0, 6'h00, 1'b0, 32'd10, 1'b0, 1'b0, 2};
    issue(v);
    bus.req0_valid = 1'b1; bus.req0_oprn = 6'h01;
    bus.req1_valid = 1'b1; bus.req1_oprn = 6'h01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid",  {31'd0, bus.rsp_valid}, 32'd1);
      chk("stall_id",     {31'd0, bus.rsp_id},    32'd0);
      chk("stall_out",    bus.rsp_out,            32'd10);
      chk("stall_zero",   {31'd0, bus.rsp_zero},  32'd0);
      chk("stall_err",    {31'd0, bus.rsp_err},   32'd0);
      chk("stall_ready",  {31'd0, bus.req0_ready | bus.req1_ready}, 32'd0);
      chk("stall_busy",   {31'd0, bus.busy},      32'd1);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    drop_inputs();
    @(negedge clk);
    chk("post_rsp_busy", {31'd0, bus.busy}, 32'd0);

    // Reset during WAIT aborts the multiply with no response.
    @(posedge clk); #1;
    bus.req1_valid = 1'b1; bus.req1_op1 = 32'd6; bus.req1_op2 = 32'd7; bus.req1_oprn = 6'h03;
    begin
      bit found;
      found = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.req1_ready) begin
          found = 1;
          break;
        end
      end
      chk("abort_grant", {31'd0, found}, 32'd1);
    end
    @(posedge clk); #1;
    drop_inputs();
    @(posedge clk); #2;
    chk("abort_busy_wait", {31'd0, bus.busy}, 32'd1);
    bus.req0_valid = 1'b1; bus.req0_oprn = 6'h01;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    drop_inputs();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    end
    @(posedge clk); #1;
    v = '{1'b1, 1'b0, 32'd5, 32'd3, 6'h01, 32'd0, 32'd0, 6'h00, 1'b0, 32'd8, 1'b0, 1'b0, 2};
    issue(v);

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter MUL_WAIT, default 1, giving extra EXEC cycles for opcode 0x03 (range 0..15).
REQ-002 The block SHALL have port CLK  input  1  system clock, all state on rising edge.
REQ-003 The block SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have ports REQ0_VALID / REQ1_VALID  input  1  requester n presents an operation.
REQ-005 The block SHALL have ports REQ0_OP1, REQ0_OP2, REQ1_OP1, REQ1_OP2  input  32  operands.
REQ-006 The block SHALL have ports REQ0_OPRN / REQ1_OPRN  input  6  ALU operation code.
REQ-007 The block SHALL have ports REQ0_READY / REQ1_READY  output  1  request accepted this edge.
REQ-008 The block SHALL have ports RSP_VALID  output  1; RSP_ID  output  1  requester index; RSP_OUT  output  32; RSP_ZERO  output  1; RSP_ERR  output  1  illegal opcode.
REQ-009 The block SHALL have port RSP_READY  input  1  response consumed.
REQ-010 The block SHALL have ports ALU_OP1, ALU_OP2  output  32; ALU_OPRN  output  6, driving the shared ALU.
REQ-011 The block SHALL have ports ALU_OUT  input  32; ALU_ZERO  input  1, from the shared ALU.
REQ-012 The block SHALL have port BUSY  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states SHALL be IDLE, EXEC, WAIT, RESP.
REQ-014 In IDLE, READYn SHALL be 1 only for the arbitration winner with VALIDn=1, combinationally; READY SHALL be 0 in all other states.
REQ-015 A request SHALL be accepted when VALIDn && READYn at a rising edge; operands, opcode and winner index latch into internal registers.
REQ-016 Arbitration SHALL be round-robin: single valid requester wins; both valid, the one not granted last wins; LAST_GNT updates on acceptance only.
REQ-017 ALU_OP1/ALU_OP2/ALU_OPRN SHALL be driven from the latched registers, stable from the cycle after acceptance until the next acceptance.
REQ-018 Legal opcodes SHALL be 0x01..0x09; acceptance of a legal opcode SHALL move IDLE->EXEC.
REQ-019 Acceptance of an illegal opcode (0x00, 0x0A..0x3F) SHALL move IDLE->RESP with RSP_OUT=0, RSP_ZERO=1, RSP_ERR=1.
REQ-020 EXEC SHALL last one cycle; for opcode 0x03 with MUL_WAIT>0, EXEC->WAIT, else EXEC->RESP capturing ALU_OUT/ALU_ZERO at the exit edge.
REQ-021 WAIT SHALL count MUL_WAIT cycles with a 4-bit counter loaded at EXEC exit, then capture ALU_OUT/ALU_ZERO and move to RESP.
REQ-022 Latency SHALL be: acceptance at edge k -> RSP_VALID=1 after edge k+2 (legal non-mul), k+2+MUL_WAIT (mul), k+1 (illegal).
REQ-023 In RESP, RSP_VALID=1 with RSP_ID, RSP_OUT, RSP_ZERO, RSP_ERR held stable until RSP_READY=1 at an edge, then RESP->IDLE.
REQ-024 RSP_ERR SHALL be 0 for every legal-opcode response.
REQ-025 No new request SHALL be accepted in the RESP->IDLE transition cycle; earliest next acceptance is the edge after return to IDLE.
REQ-026 A requester dropping VALID before acceptance SHALL cause no state change; the block never holds a grant across cycles.
REQ-027 Inputs VALID/OP/OPRN after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-028 RST low SHALL asynchronously force IDLE, LAST_GNT=1 (REQ0 wins first tie), counter=0, all result and ALU operand registers 0.
REQ-029 While RST low, all outputs SHALL be 0, including READY, RSP_VALID and BUSY.
REQ-030 RST asserted mid-operation SHALL abort it with no response; release SHALL resume in IDLE.

Verification
REQ-031 REQ0 add OP1=5, OP2=3, OPRN=0x01 -> READY0 at edge k, RSP_VALID after k+2, RSP_ID=0, RSP_OUT=8, RSP_ZERO=0, RSP_ERR=0.
REQ-032 Both valid continuously, REQ0 sub 7-7, REQ1 or 0xF0|0x0F -> grants 0,1,0,1; responses OUT=0/ZERO=1 and OUT=0xFF/ZERO=0.
REQ-033 REQ1 mul 6*7, OPRN=0x03, MUL_WAIT=1 -> RSP_VALID after k+3, RSP_OUT=42.
REQ-034 REQ0 OPRN=0x0C -> RSP_VALID after k+1, RSP_OUT=0, RSP_ZERO=1, RSP_ERR=1, ALU not used.
REQ-035 RSP_READY held 0 for 5 cycles -> response fields stable, READY0/READY1=0, BUSY=1 throughout.
REQ-036 RST pulsed low during WAIT -> immediate all-zero outputs, no response, next REQ0 add completes normally.
